// File: rtl/stage_me_pipe.sv
// Memory stage: byte-lane data memory with LATENCY-cycle access and an optional
// misaligned-access trap (enabled by defining STAGE_ME_MISALIGN_TRAP_EN).
module stage_me_pipe #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic        rmem_me,
    input  logic        wmem_me,
    input  logic [1:0]  size_me,
    input  logic        sext_me,
    input  logic [31:0] addr,
    input  logic [31:0] in_me,
    output logic        stall_me,
    output logic        valid_out,
    output logic [31:0] mo_me,
    output logic        misalign_me
);
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam bit          MultiCycle = (LATENCY > 1);
    localparam logic [2:0]  CntInit    = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;

    logic          op_store_q, op_load_q, op_sext_q;
    logic [1:0]    op_size_q;
    logic [AW+1:0] op_addr_q;
    logic [31:0]   op_data_q;

    logic          valid_q;
    logic [31:0]   mo_q;

    logic [31:0]   mem [DEPTH];

    logic          is_mem, trap, accept, mem_go, fire;
    logic          acc_store, acc_load, acc_sext;
    logic [1:0]    acc_size;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rword, rbyte_sh, rhalf_sh, load_val, wdata;
    logic [3:0]    wmask;

    assign is_mem = rmem_me | wmem_me;
    assign accept = (state_q == StIdle) & valid_in;

`ifdef STAGE_ME_MISALIGN_TRAP_EN
    assign trap = is_mem & (((size_me == 2'b01) & addr[0]) |
                            (size_me[1] & (addr[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    assign mem_go = accept & is_mem & ~trap;

    // Single-cycle access uses the live inputs; multi-cycle uses the copy taken at accept.
    assign fire      = MultiCycle ? ((state_q == StBusy) && (cnt_q == 3'd0)) : mem_go;
    assign acc_store = MultiCycle ? op_store_q : wmem_me;
    assign acc_load  = MultiCycle ? op_load_q  : (rmem_me & ~wmem_me);
    assign acc_sext  = MultiCycle ? op_sext_q  : sext_me;
    assign acc_size  = MultiCycle ? op_size_q  : size_me;
    assign acc_addr  = MultiCycle ? op_addr_q  : addr[AW+1:0];
    assign acc_data  = MultiCycle ? op_data_q  : in_me;
    assign acc_idx   = acc_addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (MultiCycle && mem_go) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end
            end
            StBusy: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign stall_me = resetn & ((MultiCycle & mem_go) | ((state_q == StBusy) & (cnt_q != 3'd0)));

    assign rword    = mem[acc_idx];
    assign rbyte_sh = rword >> {acc_addr[1:0], 3'b000};
    assign rhalf_sh = rword >> {acc_addr[1], 4'b0000};

    always_comb begin
        case (acc_size)
            2'b00:   load_val = {{24{acc_sext & rbyte_sh[7]}}, rbyte_sh[7:0]};
            2'b01:   load_val = {{16{acc_sext & rhalf_sh[15]}}, rhalf_sh[15:0]};
            default: load_val = rword;
        endcase
    end

    always_comb begin
        wdata = acc_data;
        wmask = 4'b1111;
        case (acc_size)
            2'b00: begin
                wdata = {4{acc_data[7:0]}};
                wmask = 4'b0001 << acc_addr[1:0];
            end
            2'b01: begin
                wdata = {2{acc_data[15:0]}};
                wmask = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Data memory is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (fire && acc_store) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_store_q <= 1'b0;
            op_load_q  <= 1'b0;
            op_sext_q  <= 1'b0;
            op_size_q  <= 2'b00;
            op_addr_q  <= '0;
            op_data_q  <= '0;
        end else if (mem_go) begin
            op_store_q <= wmem_me;
            op_load_q  <= rmem_me & ~wmem_me;
            op_sext_q  <= sext_me;
            op_size_q  <= size_me;
            op_addr_q  <= addr[AW+1:0];
            op_data_q  <= in_me;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            mo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Non-memory ops and trapped accesses complete the cycle after accept.
            valid_q <= (accept & ~mem_go) | fire;
            if (accept && !is_mem) begin
                mo_q <= addr;
            end else if (fire && acc_load) begin
                mo_q <= load_val;
            end
        end
    end

`ifdef STAGE_ME_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept & trap;
        end
    end

    assign misalign_me = misalign_q;
`else
    assign misalign_me = 1'b0;
`endif

    assign valid_out = valid_q;
    assign mo_me     = mo_q;

    logic unused_bits;
    assign unused_bits = ^{addr[31:AW+2], rbyte_sh[31:8], rhalf_sh[31:16]};

endmodule

// File: tb/tb_stage_me_pipe.sv
// Bench for stage_me_pipe: one LATENCY=1 and one LATENCY=3 instance, scoreboard-checked.
module tb_stage_me_pipe;
    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic        vi [2];
    logic        rm [2];
    logic        wm [2];
    logic        sx [2];
    logic [1:0]  sz [2];
    logic [31:0] ad [2];
    logic [31:0] dn [2];
    logic        st [2];
    logic        vo [2];
    logic        mis [2];
    logic [31:0] mo [2];

    typedef struct {
        int          d;
        logic [31:0] mo;
        logic        mis;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mmem [2][1024];
    logic [31:0] mmo [2];
    logic [31:0] last_mo [2];
    int          lat [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    stage_me_pipe #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clock(clock), .resetn(resetn), .valid_in(vi[0]), .rmem_me(rm[0]), .wmem_me(wm[0]),
        .size_me(sz[0]), .sext_me(sx[0]), .addr(ad[0]), .in_me(dn[0]), .stall_me(st[0]),
        .valid_out(vo[0]), .mo_me(mo[0]), .misalign_me(mis[0])
    );

    stage_me_pipe #(.DEPTH(1024), .LATENCY(3)) dut_l3 (
        .clock(clock), .resetn(resetn), .valid_in(vi[1]), .rmem_me(rm[1]), .wmem_me(wm[1]),
        .size_me(sz[1]), .sext_me(sx[1]), .addr(ad[1]), .in_me(dn[1]), .stall_me(st[1]),
        .valid_out(vo[1]), .mo_me(mo[1]), .misalign_me(mis[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one instruction, pushes its expected completion, then follows it cycle by cycle.
    task automatic op(input int d, input logic r, input logic w, input logic [1:0] s,
                      input logic x, input logic [31:0] a, input logic [31:0] din);
        logic        is_mem, trap;
        int          lexp, idx;
        logic [31:0] wd, sh;
        exp_t        e;
        is_mem = r | w;
        trap   = 1'b0;
`ifdef STAGE_ME_MISALIGN_TRAP_EN
        trap = is_mem && ((s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00));
`endif
        idx = int'(a[11:2]);
        if (!is_mem) begin
            mmo[d] = a;
        end else if (!trap) begin
            wd = mmem[d][idx];
            if (w) begin
                case (s)
                    2'b00:   wd[8*a[1:0] +: 8] = din[7:0];
                    2'b01:   wd[16*a[1] +: 16] = din[15:0];
                    default: wd = din;
                endcase
                mmem[d][idx] = wd;
            end else begin
                case (s)
                    2'b00: begin
                        sh = wd >> (8 * a[1:0]);
                        mmo[d] = x ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
                    end
                    2'b01: begin
                        sh = wd >> (16 * a[1]);
                        mmo[d] = x ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
                    end
                    default: mmo[d] = wd;
                endcase
            end
        end
        e.d = d;
        e.mo = mmo[d];
        e.mis = trap;
        sbq.push_back(e);
        lexp = (is_mem && !trap) ? lat[d] : 1;

        vi[d] = 1'b1; rm[d] = r; wm[d] = w; sz[d] = s; sx[d] = x; ad[d] = a; dn[d] = din;
        for (int k = 0; k <= lexp; k++) begin
            @(negedge clock);
            chk("stall", 32'(st[d]), 32'(is_mem && !trap && k <= lat[d] - 2));
            chk("valid_out", 32'(vo[d]), 32'(k == lexp));
            if (k == lexp) begin
                if (sbq.size() == 0) begin
                    chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("mo_me", mo[e.d], e.mo);
                    chk("misalign_me", 32'(mis[e.d]), 32'(e.mis));
                end
                last_mo[d] = mo[d];
            end
            @(posedge clock);
            #1;
            if (k + 1 == lexp) vi[d] = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] exp_mis;
        lat[0] = 1;
        lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            vi[d] = 1'b0; rm[d] = 1'b0; wm[d] = 1'b0; sz[d] = 2'b00; sx[d] = 1'b0;
            ad[d] = '0; dn[d] = '0; mmo[d] = '0; last_mo[d] = '0;
        end

        #1 resetn = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", 32'(vo[d]), 32'd0);
            chk("rst_mo", mo[d], 32'd0);
            chk("rst_stall", 32'(st[d]), 32'd0);
            chk("rst_mis", 32'(mis[d]), 32'd0);
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // LATENCY=1 basic word path
        op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("l1_word_load", last_mo[0], 32'hDEADBEEF);

        // Byte lanes and extension
        op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h00000000);
        op(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFF80);
        op(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("byte_sext", last_mo[0], 32'hFFFFFF80);
        op(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("byte_zext", last_mo[0], 32'h00000080);
        op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("byte_word_view", last_mo[0], 32'h80000000);

        // Half lanes
        op(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
        op(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        chk("half_sext", last_mo[0], 32'hFFFFBEEF);
        op(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        op(0, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

        // Both request bits set behaves as a store
        op(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0BADF00D);
        op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("rw_is_store", last_mo[0], 32'h0BADF00D);

        // Address wrap modulo DEPTH words
        op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        op(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h00001000, 32'h55);
        op(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        chk("wrap", last_mo[0], 32'h00000055);

        // Misaligned word store
        op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111);
        op(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hCAFEF00D);
        op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
`ifdef STAGE_ME_MISALIGN_TRAP_EN
        exp_mis = 32'h11111111;
`else
        exp_mis = 32'hCAFEF00D;
`endif
        chk("misalign_mem", last_mo[0], exp_mis);

        // LATENCY=3 load timing and pass-through
        op(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
        op(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("l3_load", last_mo[1], 32'h12345678);
        op(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0);
        chk("l3_passthru", last_mo[1], 32'h00001234);

        // Reset during a pending LATENCY=3 store aborts it
        vi[1] = 1'b1; rm[1] = 1'b0; wm[1] = 1'b1; sz[1] = 2'b10; sx[1] = 1'b0;
        ad[1] = 32'h20; dn[1] = 32'hA5A5A5A5;
        @(negedge clock);
        chk("abort_stall_t", 32'(st[1]), 32'd1);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        vi[1] = 1'b0;
        #1;
        chk("abort_rst_valid", 32'(vo[1]), 32'd0);
        chk("abort_rst_stall", 32'(st[1]), 32'd0);
        chk("abort_rst_mo", mo[1], 32'd0);
        chk("abort_rst_mo_l1", mo[0], 32'd0);
        mmo[0] = '0;
        mmo[1] = '0;
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("abort_no_valid", 32'(vo[1]), 32'd0);
        end
        @(posedge clock);
        #1;
        op(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("abort_prior", last_mo[1], 32'h12345678);
        op(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        chk("mem_survives_rst", last_mo[0], 32'h0BADF00D);

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
